rabbit_serial_rx: RTL

RABBIT_SERIAL_RX -- requirements
Module: rabbit_serial_rx

---
 rtl/rabbit_serial_rx_if.sv | 36 +++
 rtl/rabbit_serial_rx.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/rabbit_serial_rx_if.sv
// rabbit_serial_rx_if
// Groups the Rabbit serial pins and the downstream frame handshake into one bundle.
//
// Signals:
//   SCLK_PE_3    asynchronous serial clock from the Rabbit; data is valid on its rising edge
//   SDIO_PE_5    asynchronous serial data from the Rabbit
//   frame_ready  downstream DDS serializer accepts the held frame
//   frame_data   last complete frame; index 0 is the first bit received
//   frame_valid  frame_data holds a frame that has not been accepted yet
//   busy         a frame is partially received
//   frame_error  one-cycle pulse on timeout, overrun or parity failure
//
// Modports:
//   master  the Rabbit / downstream side; drives the pins and frame_ready
//   slave   the receiver; drives the frame outputs
interface rabbit_serial_rx_if #(
    parameter int FRAME_BITS = 184
);
    logic                  SCLK_PE_3;
    logic                  SDIO_PE_5;
    logic                  frame_ready;
    logic [0:FRAME_BITS-1] frame_data;
    logic                  frame_valid;
    logic                  busy;
    logic                  frame_error;

    modport master (
        output SCLK_PE_3, SDIO_PE_5, frame_ready,
        input  frame_data, frame_valid, busy, frame_error
    );

    modport slave (
        input  SCLK_PE_3, SDIO_PE_5, frame_ready,
        output frame_data, frame_valid, busy, frame_error
    );
endinterface

// File: rtl/rabbit_serial_rx.sv
// rabbit_serial_rx
// Receives fixed-length frames from the Rabbit over an asynchronous SCLK/SDIO
// pair. It oversamples both pins with ten_MHz_ext and holds the last complete
// frame for the downstream DDS serializer.
//
// Parameters:
//   FRAME_BITS      payload bits per frame
//   TIMEOUT_CYCLES  maximum clock cycles allowed between SCLK rising edges inside a frame
//   SYNC_STAGES     synchronizer depth (2 or 3)
//
// Ports:
//   ten_MHz_ext  sole clock; all logic runs on its rising edge
//   reset        synchronous, active-high reset
//   rx_if        rabbit_serial_rx_if.slave (serial pins in, frame handshake out)
//
// Optional feature:
//   Define RABBIT_RX_PARITY_EN to add one trailing even-parity bit to every frame.
//   A frame with bad parity is dropped and frame_error pulses.
module rabbit_serial_rx #(
    parameter int FRAME_BITS     = 184,
    parameter int TIMEOUT_CYCLES = 2000,
    parameter int SYNC_STAGES    = 2
) (
    input logic               ten_MHz_ext,
    input logic               reset,
    rabbit_serial_rx_if.slave rx_if
);

`ifdef RABBIT_RX_PARITY_EN
    localparam int SHIFT_BITS = FRAME_BITS + 1;
`else
    localparam int SHIFT_BITS = FRAME_BITS;
`endif
    localparam int CNT_W  = $clog2(FRAME_BITS + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT    = CNT_W'(SHIFT_BITS - 1);
    localparam logic [IDLE_W-1:0] TIMEOUT_VAL = IDLE_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] sdio_sync_q, sdio_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [IDLE_W-1:0]      idle_cnt_q, idle_cnt_d;
    logic [0:SHIFT_BITS-1]  shift_q, shift_d;
    logic [0:FRAME_BITS-1]  frame_data_q, frame_data_d;
    logic                   frame_valid_q, frame_valid_d;
    logic                   frame_error_q, frame_error_d;

    logic sclk_s;
    logic sdio_s;
    logic sclk_edge;
    logic frame_good;

    // SDIO runs through the same number of stages as SCLK, so the data bit
    // seen at the detected edge is the one that was on the pin with that edge.
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign sdio_s    = sdio_sync_q[SYNC_STAGES-1];
    assign sclk_edge = sclk_s & ~sclk_prev_q;

`ifdef RABBIT_RX_PARITY_EN
    // Payload plus parity bit must contain an even number of ones.
    assign frame_good = ~(^shift_q);
`else
    assign frame_good = 1'b1;
`endif

    // State register and all datapath flops.
    always_ff @(posedge ten_MHz_ext) begin
        if (reset) begin
            state_q       <= IDLE;
            sclk_sync_q   <= '0;
            sdio_sync_q   <= '0;
            sclk_prev_q   <= 1'b0;
            bit_cnt_q     <= '0;
            idle_cnt_q    <= '0;
            shift_q       <= '0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sclk_sync_q   <= sclk_sync_d;
            sdio_sync_q   <= sdio_sync_d;
            sclk_prev_q   <= sclk_prev_d;
            bit_cnt_q     <= bit_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            shift_q       <= shift_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    // Next-state logic for the synchronizers, the receive FSM and the holding register.
    always_comb begin
        state_d       = state_q;
        sclk_sync_d   = {sclk_sync_q[SYNC_STAGES-2:0], rx_if.SCLK_PE_3};
        sdio_sync_d   = {sdio_sync_q[SYNC_STAGES-2:0], rx_if.SDIO_PE_5};
        sclk_prev_d   = sclk_s;
        bit_cnt_d     = bit_cnt_q;
        idle_cnt_d    = idle_cnt_q;
        shift_d       = shift_q;
        frame_data_d  = frame_data_q;
        frame_valid_d = frame_valid_q;
        frame_error_d = 1'b0;

        // The idle counter saturates so that it can never wrap back below the limit.
        if (sclk_edge) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != TIMEOUT_VAL) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end

        // The downstream accept clears the holding register; a frame finishing
        // in DONE during this same cycle overrides the clear below.
        if (frame_valid_q && rx_if.frame_ready) begin
            frame_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                if (sclk_edge) begin
                    shift_d[0] = sdio_s;
                    bit_cnt_d  = CNT_W'(1);
                    state_d    = (LAST_BIT == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (sclk_edge) begin
                    shift_d[bit_cnt_q] = sdio_s;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (idle_cnt_q == TIMEOUT_VAL) begin
                    frame_error_d = 1'b1;
                    bit_cnt_d     = '0;
                    state_d       = IDLE;
                end
            end
            DONE: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
                if (!frame_good) begin
                    frame_error_d = 1'b1;
                end else if (!frame_valid_q || rx_if.frame_ready) begin
                    frame_data_d  = shift_q[0:FRAME_BITS-1];
                    frame_valid_d = 1'b1;
                end else begin
                    frame_error_d = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    assign rx_if.frame_data  = frame_data_q;
    assign rx_if.frame_valid = frame_valid_q;
    assign rx_if.busy        = (state_q == SHIFT);
    assign rx_if.frame_error = frame_error_q;

endmodule
